// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: DEPTH-deep valid/ready pipeline register with bubble collapse, flush and occupancy count
module pipe_stage_reg #(
    parameter int DATA_W = 101,
    parameter int CTRL_W = 5,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  count
);
    logic [DEPTH-1:0]  v_q, v_d, adv;
    logic [DEPTH:0]    ld;
    logic [DATA_W-1:0] d_q [DEPTH];
    logic [DATA_W-1:0] d_d [DEPTH];
    logic [CTRL_W-1:0] c_q [DEPTH];
    logic [CTRL_W-1:0] c_d [DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              acc;

    // a slot moves forward when the slot ahead is empty or is itself moving
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = v_q[DEPTH-1] & out_ready;
        for (int i = DEPTH - 2; i >= 0; i--)
            adv[i] = v_q[i] & (~v_q[i+1] | adv[i+1]);
    end

    assign in_ready = ~v_q[0] | adv[0];
    assign acc      = in_valid & in_ready;
    // ld[i] means slot i is refilled this edge: from the input for slot 0, from slot i-1 otherwise
    assign ld       = {adv, acc};

    // next slot contents: refill, vacate, or stall; flush kills valids and controls but leaves data alone
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            v_d[i] = ld[i] ? 1'b1 : (adv[i] ? 1'b0 : v_q[i]);
            d_d[i] = (ld[i] && !flush) ? ((i == 0) ? in_data : d_q[(i == 0) ? 0 : i - 1]) : d_q[i];
            c_d[i] = ld[i] ? ((i == 0) ? in_ctrl : c_q[(i == 0) ? 0 : i - 1]) : (adv[i] ? '0 : c_q[i]);
            if (flush) begin
                v_d[i] = 1'b0;
                c_d[i] = '0;
            end
        end
    end

    // occupancy is the popcount of the next valid vector so it always matches v after the edge
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_d = cnt_d + CNT_W'(v_d[i]);
    end

    // slot state registers; reset wins over flush and input
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else begin
            v_q   <= v_d;
            cnt_q <= cnt_d;
            d_q   <= d_d;
            c_q   <= c_d;
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign out_ctrl  = v_q[DEPTH-1] ? c_q[DEPTH-1] : '0;
    assign count     = cnt_q;
endmodule
